// File: rtl/ov7670_frame_writer_pkg.sv
// Shared types, defaults and pixel helpers for the OV7670 frame writer.
// Optional build macro: OV7670_FRAME_WRITER_TESTPAT_EN (colour-bar test pattern).
package ov7670_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    CAPTURE = 1'b1
  } state_e;

  localparam int H_RES_DEF = 320;
  localparam int V_RES_DEF = 240;

  // hi = {R4..R0,G5..G3}, lo = {G2..G0,B4..B0}; keep the top 4 bits of each channel
  function automatic logic [11:0] rgb565_to_444(input logic [7:0] hi, input logic [7:0] lo);
    logic unused_bits;
    unused_bits = ^{hi[3], lo[6:5], lo[0]};
    return {hi[7:4], hi[2:0], lo[7], lo[4:1]};
  endfunction

  function automatic logic [11:0] tp_colour(input logic [2:0] bar);
    case (bar)
      3'd0:    return 12'hFFF;
      3'd1:    return 12'hFF0;
      3'd2:    return 12'h0FF;
      3'd3:    return 12'h0F0;
      3'd4:    return 12'hF0F;
      3'd5:    return 12'hF00;
      3'd6:    return 12'h00F;
      default: return 12'h000;
    endcase
  endfunction

endpackage

// File: rtl/ov7670_frame_writer_if.sv
// Camera-side inputs and frame-buffer-side outputs of the frame writer.
interface ov7670_frame_writer_if #(
  parameter int ADDR_W = 17
);
  logic              capture_en;
  logic              vsync;
  logic              href;
  logic [7:0]        pix_data;
  logic              fb_we;
  logic [ADDR_W-1:0] fb_wAddr;
  logic [11:0]       fb_wdata;
  logic              frame_done;
  logic              busy;

  modport master (
    output capture_en, vsync, href, pix_data,
    input  fb_we, fb_wAddr, fb_wdata, frame_done, busy
  );

  modport slave (
    input  capture_en, vsync, href, pix_data,
    output fb_we, fb_wAddr, fb_wdata, frame_done, busy
  );
endinterface

// File: rtl/ov7670_frame_writer_byte_packer.sv
// Pairs camera bytes into RGB565 pixels and packs them to RGB444.
module ov7670_byte_packer
  import ov7670_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_vld_i,
  input  logic [7:0]  byte_i,
  output logic        pix_valid_o,
  output logic [11:0] pix_data_o
);
  logic       phase_q;
  logic [7:0] hi_q;

  // Any gap in byte_vld (href low, IDLE) returns to phase 0, dropping an odd byte.
  always_ff @(posedge clk) begin
    if (reset) phase_q <= 1'b0;
    else       phase_q <= byte_vld_i & ~phase_q;
    if (byte_vld_i && !phase_q) hi_q <= byte_i;
  end

  assign pix_valid_o = byte_vld_i & phase_q;
  assign pix_data_o  = rgb565_to_444(hi_q, byte_i);
endmodule

// File: rtl/ov7670_frame_writer.sv
// OV7670 capture into a H_RES x V_RES RGB444 frame buffer via a running write address.
// Build macro OV7670_FRAME_WRITER_TESTPAT_EN replaces camera pixels with 8 colour bars.
module ov7670_frame_writer
  import ov7670_pkg::*;
#(
  parameter int H_RES  = H_RES_DEF,
  parameter int V_RES  = V_RES_DEF,
  parameter int ADDR_W = 17
) (
  input logic                 clk,
  input logic                 reset,
  ov7670_frame_writer_if.slave bus
);
  localparam int COL_W = $clog2(H_RES + 1);
  localparam int LIN_W = $clog2(V_RES + 1);
  localparam logic [COL_W-1:0]  COL_MAX     = COL_W'(H_RES);
  localparam logic [LIN_W-1:0]  LIN_MAX     = LIN_W'(V_RES);
  localparam logic [ADDR_W-1:0] LINE_STRIDE = ADDR_W'(H_RES);

  state_e            state_q;
  logic              vsync_d_q, href_d_q;
  logic [COL_W-1:0]  col_q;
  logic [LIN_W-1:0]  line_q;
  logic [ADDR_W-1:0] addr_q, base_q;
  logic              fb_we_q, frame_done_q;
  logic [ADDR_W-1:0] fb_waddr_q;
  logic [11:0]       fb_wdata_q, fb_wdata_d;

  logic        pix_vld;
  logic [11:0] pix_rgb;
  logic        frame_start, frame_end, line_end, wr;

  ov7670_byte_packer u_packer (
    .clk         (clk),
    .reset       (reset),
    .byte_vld_i  ((state_q == CAPTURE) && bus.href),
    .byte_i      (bus.pix_data),
    .pix_valid_o (pix_vld),
    .pix_data_o  (pix_rgb)
  );

`ifdef OV7670_FRAME_WRITER_TESTPAT_EN
  localparam logic [COL_W-1:0] BAR_W = COL_W'(H_RES / 8);
  logic unused_pix;
  assign unused_pix = ^pix_rgb;
`endif

  always_comb begin
    frame_start = (state_q == IDLE) && vsync_d_q && !bus.vsync && bus.capture_en;
    frame_end   = (state_q == CAPTURE) && !vsync_d_q && bus.vsync;
    line_end    = (state_q == CAPTURE) && href_d_q && !bus.href;
    wr          = pix_vld && (col_q < COL_MAX) && (line_q < LIN_MAX);
`ifdef OV7670_FRAME_WRITER_TESTPAT_EN
    fb_wdata_d  = tp_colour(3'(col_q / BAR_W));
`else
    fb_wdata_d  = pix_rgb;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      vsync_d_q    <= 1'b0;
      href_d_q     <= 1'b0;
      col_q        <= '0;
      line_q       <= '0;
      addr_q       <= '0;
      base_q       <= '0;
      fb_we_q      <= 1'b0;
      fb_waddr_q   <= '0;
      fb_wdata_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      vsync_d_q    <= bus.vsync;
      href_d_q     <= bus.href;
      fb_we_q      <= wr;
      frame_done_q <= frame_end && (line_q == LIN_MAX);
      if (wr) begin
        fb_waddr_q <= addr_q;
        fb_wdata_q <= fb_wdata_d;
      end
      case (state_q)
        IDLE: begin
          if (frame_start) begin
            state_q <= CAPTURE;
            col_q   <= '0;
            line_q  <= '0;
            addr_q  <= '0;
            base_q  <= '0;
          end
        end
        CAPTURE: begin
          if (frame_end) state_q <= IDLE;
          // Each stored line starts at line*H_RES regardless of how many pixels it had.
          if (line_end) begin
            col_q <= '0;
            if (col_q != '0 && line_q < LIN_MAX) begin
              line_q <= line_q + LIN_W'(1);
              base_q <= base_q + LINE_STRIDE;
              addr_q <= base_q + LINE_STRIDE;
            end
          end else if (pix_vld) begin
            if (col_q < COL_MAX) col_q <= col_q + COL_W'(1);
            if (wr) addr_q <= addr_q + ADDR_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.fb_we      = fb_we_q;
  assign bus.fb_wAddr   = fb_waddr_q;
  assign bus.fb_wdata   = fb_wdata_q;
  assign bus.frame_done = frame_done_q;
  assign bus.busy       = (state_q == CAPTURE);
endmodule

// File: tb/tb_ov7670_frame_writer.sv
// Directed bench for ov7670_frame_writer with a pixel-level reference model.
module tb_ov7670_frame_writer;
  localparam int H  = 320;
  localparam int V  = 8;
  localparam int AW = 12;

  logic clk;
  logic reset;

  ov7670_frame_writer_if #(.ADDR_W(AW)) bus ();

  ov7670_frame_writer #(.H_RES(H), .V_RES(V), .ADDR_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int addr;
    int data;
  } wr_t;

  wr_t expq[$];
  int  log_addr[$];
  int  log_data[$];
  int  nvec = 0;
  int  nerr = 0;
  int  cyc = 0;
  int  exp_fd = -1;
  int  fd_count = 0;
  bit  started = 0;
  bit  m_cap = 0;
  int  m_line = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // Expected RGB444 from the camera's RGB565 fields (or the colour bar in pattern builds).
  function automatic int exp_pix(input int hi, input int lo, input int pix);
`ifdef OV7670_FRAME_WRITER_TESTPAT_EN
    int bars[8] = '{'hFFF, 'hFF0, 'h0FF, 'h0F0, 'hF0F, 'hF00, 'h00F, 'h000};
    return bars[pix / (H / 8)];
`else
    int r5, g6, b5;
    r5 = hi >> 3;
    g6 = ((hi & 7) << 3) | (lo >> 5);
    b5 = lo & 31;
    return ((r5 >> 1) << 8) | ((g6 >> 2) << 4) | (b5 >> 1);
`endif
  endfunction

  task automatic send_bytes(input logic [7:0] b[$]);
    int hi = 0;
    bus.href = 1'b1;
    for (int i = 0; i < b.size(); i++) begin
      bus.pix_data = b[i];
      tick();
      if (i % 2 == 0) hi = int'(b[i]);
      else if (m_cap && (i / 2) < H && m_line < V)
        expq.push_back('{cyc, m_line * H + i / 2, exp_pix(hi, int'(b[i]), i / 2)});
    end
    bus.href = 1'b0;
    tick();
    if (m_cap && b.size() >= 2 && m_line < V) m_line++;
    repeat (3) tick();
  endtask

  task automatic send_line(input int nbytes, input int tag);
    logic [7:0] b[$];
    for (int i = 0; i < nbytes; i++) b.push_back(8'((i * 37 + tag * 11 + 5) & 255));
    send_bytes(b);
  endtask

  task automatic vs_fall(input logic en);
    bus.capture_en = en;
    bus.vsync = 1'b0;
    tick();
    if (en && !m_cap) begin
      m_cap  = 1;
      m_line = 0;
    end
    repeat (3) tick();
  endtask

  task automatic vs_rise(input int gap);
    bus.vsync = 1'b1;
    tick();
    if (m_cap) begin
      if (m_line == V) exp_fd = cyc;
      m_cap = 0;
    end
    repeat (gap) tick();
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
  endtask

  // Cycle-by-cycle comparison of the DUT against the model.
  always @(negedge clk) begin : compare
    logic e_we;
    if (started) begin
      e_we = (expq.size() > 0) && (expq[0].cyc == cyc);
      chk("fb_we", 32'(bus.fb_we), 32'(e_we));
      if (e_we) begin
        if (bus.fb_we === 1'b1) begin
          chk("fb_wAddr", 32'(bus.fb_wAddr), 32'(expq[0].addr));
          chk("fb_wdata", 32'(bus.fb_wdata), 32'(expq[0].data));
        end
        void'(expq.pop_front());
      end
      if (bus.fb_we === 1'b1) begin
        log_addr.push_back(int'(bus.fb_wAddr));
        log_data.push_back(int'(bus.fb_wdata));
      end
      chk("frame_done", 32'(bus.frame_done), 32'(cyc == exp_fd));
      if (bus.frame_done === 1'b1) fd_count++;
      chk("busy", 32'(bus.busy), 32'(m_cap));
    end
  end

  initial begin
    logic [7:0] pk[$];
    bus.capture_en = 1'b1;
    bus.vsync      = 1'b1;
    bus.href       = 1'b0;
    bus.pix_data   = 8'h00;
    reset          = 1'b1;
    tick();
    started = 1;
    tick();
    chk("reset_we",    32'(bus.fb_we), 0);
    chk("reset_addr",  32'(bus.fb_wAddr), 0);
    chk("reset_data",  32'(bus.fb_wdata), 0);
    chk("reset_done",  32'(bus.frame_done), 0);
    chk("reset_busy",  32'(bus.busy), 0);
    reset = 1'b0;
    repeat (3) tick();

    // Packing vectors, then an aborted frame after a few lines.
    clear_log();
    vs_fall(1'b1);
    pk = '{8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F, 8'hFF, 8'hFF};
    send_bytes(pk);
    for (int l = 1; l < 4; l++) send_line(2 * H, l);
    vs_rise(4);
`ifndef OV7670_FRAME_WRITER_TESTPAT_EN
    chk("pack_F800", 32'(log_data[0]), 32'h0F00);
    chk("pack_07E0", 32'(log_data[1]), 32'h00F0);
    chk("pack_001F", 32'(log_data[2]), 32'h000F);
    chk("pack_FFFF", 32'(log_data[3]), 32'h0FFF);
`endif
    chk("pack_addr3", 32'(log_addr[3]), 3);
    chk("line1_start", 32'(log_addr[4]), 320);
    chk("abort_no_done", 32'(fd_count), 0);
    chk("abort_busy", 32'(bus.busy), 0);

    // Full frame with capture_en dropped mid-frame, then back-to-back overlong frame.
    clear_log();
    vs_fall(1'b1);
    bus.capture_en = 1'b0;
    for (int l = 0; l < V; l++) send_line(2 * H, l);
    vs_rise(1);
    chk("full_writes", 32'(log_addr.size()), 2560);
    chk("full_first", 32'(log_addr[0]), 0);
    chk("full_last", 32'(log_addr[2559]), 2559);
    chk("full_done", 32'(fd_count), 1);

    clear_log();
    vs_fall(1'b1);
    send_line(700, 0);
    for (int l = 1; l < 10; l++) send_line(2 * H, l);
    vs_rise(4);
    chk("long_writes", 32'(log_addr.size()), 2560);
    chk("long_line1", 32'(log_addr[320]), 320);
    chk("long_last", 32'(log_addr[log_addr.size() - 1]), 2559);
    chk("long_done", 32'(fd_count), 2);

    // Short odd line.
    clear_log();
    vs_fall(1'b1);
    send_line(101, 3);
    chk("short_writes", 32'(log_addr.size()), 50);
    send_line(2 * H, 4);
    vs_rise(4);
    chk("short_last", 32'(log_addr[49]), 49);
    chk("short_next", 32'(log_addr[50]), 320);

    // capture_en low at frame start.
    clear_log();
    vs_fall(1'b0);
    send_line(2 * H, 5);
    send_line(2 * H, 6);
    vs_rise(4);
    chk("noen_writes", 32'(log_addr.size()), 0);
    chk("noen_busy", 32'(bus.busy), 0);

    // Reset in the middle of a line, on the cycle of a second byte.
    clear_log();
    vs_fall(1'b1);
    for (int l = 0; l < 3; l++) send_line(2 * H, l);
    bus.href = 1'b1;
    bus.pix_data = 8'hF8;
    tick();
    bus.pix_data = 8'h00;
    tick();
    expq.push_back('{cyc, m_line * H, exp_pix(8'hF8, 8'h00, 0)});
    bus.pix_data = 8'h07;
    tick();
    bus.pix_data = 8'hE0;
    reset = 1'b1;
    tick();
    m_cap = 0;
    m_line = 0;
    chk("rst_we",   32'(bus.fb_we), 0);
    chk("rst_addr", 32'(bus.fb_wAddr), 0);
    chk("rst_data", 32'(bus.fb_wdata), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    reset = 1'b0;
    bus.href = 1'b0;
    repeat (3) tick();
    send_line(2 * H, 7);
    chk("rst_writes", 32'(log_addr.size()), 3 * 320 + 1);
    vs_rise(4);
    vs_fall(1'b1);
    send_line(2 * H, 8);
    vs_rise(4);
    chk("rst_restart", 32'(log_addr[961]), 0);
    chk("rst_no_done", 32'(fd_count), 2);
    chk("queue_empty", 32'(expq.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/ov7670_frame_writer.md
Name: ov7670_frame_writer

Overview:
- Capture stage directly upstream of the frame buffer; its write port is the producer of the 320x240 RGB444 image that the VGA output stage reads and upscales.
- Samples the OV7670 byte stream (vsync/href/8-bit data), packs RGB565 byte pairs into 12-bit RGB444 and drives frame buffer write enable, address and data.
- Runs on the camera pixel clock, connected as clk.

Parameters:
- H_RES, 320, pixels stored per line; extra pixels in a line are dropped
- V_RES, 240, lines stored per frame; extra lines are dropped
- ADDR_W, 17, frame buffer address width; must satisfy 2^ADDR_W >= H_RES*V_RES

Ports:
- clk  in  1  camera pixel clock; sole clock
- reset  in  1  synchronous, active-high reset
- capture_en  in  1  allows a new frame to start; sampled only at frame start
- vsync  in  1  camera vsync, active-high during vertical blanking
- href  in  1  camera href, high while line bytes are valid
- pix_data  in  8  camera data byte
- fb_we  out  1  frame buffer write enable
- fb_wAddr  out  ADDR_W  frame buffer write address
- fb_wdata  out  12  RGB444 pixel {R[3:0],G[3:0],B[3:0]}
- frame_done  out  1  one-cycle pulse when a complete frame is written
- busy  out  1  high while in CAPTURE

Behaviour:
- Reset:
  - fb_we=0, fb_wAddr=0, fb_wdata=0, frame_done=0, busy=0.
  - State=IDLE; byte phase=0; column and line counters=0; vsync_d=0.
- Inputs are used directly. The camera is synchronous to clk, so there is no synchronizer.
- Frame start, IDLE -> CAPTURE:
  - Condition: falling edge of vsync (vsync_d=1, vsync=0) with capture_en=1.
  - Action: clear address, column, line and phase.
  - If capture_en=0 at the falling edge, stay in IDLE.
- CAPTURE, href=1:
  - Phase 0: latch the byte as hi = {R4..R0,G5..G3}. Phase becomes 1.
  - Phase 1: the byte is lo = {G2..G0,B4..B0}. Phase becomes 0.
  - Phase 1 pixel: if column < H_RES and line < V_RES, the next cycle has fb_we=1, fb_wdata = {R[4:1],G[5:2],B[4:1]}, fb_wAddr = current running address.
  - The running address is a counter that increments by one per written pixel. No multiplier.
  - The column counter increments on every phase-1 byte and saturates at H_RES.
- Latency: fb_we and the other write outputs are registered; they are valid exactly 1 cycle after the second byte is sampled. fb_we is low in every other cycle.
- Line end (href falling edge in CAPTURE):
  - If column > 0, line increments, saturating at V_RES.
  - Column and phase are cleared.
  - An odd trailing byte is discarded.
- Short lines: if a line has fewer than H_RES pixels, the running address still advances to line*H_RES at the line end. Lines never shift.
- Frame end (vsync rising edge in CAPTURE):
  - If line == V_RES, pulse frame_done for 1 cycle (the cycle after the edge).
  - Otherwise the frame is aborted with no pulse. The partially written data stays in the buffer.
  - In both cases go to IDLE.
- Re-arm: a frame that ends in IDLE can be followed directly by the next vsync falling edge, so back-to-back frames lose nothing.
- capture_en dropping mid-frame has no effect; the current frame completes.
- reset asserted mid-frame returns everything to reset values on the next edge. No write is issued in that cycle.
- Bounds: fb_wAddr never exceeds H_RES*V_RES-1.
- busy = (state == CAPTURE).

Optional Feature:
- Macro: OV7670_FRAME_WRITER_TESTPAT_EN.
- Defined:
  - pix_data is ignored.
  - fb_wdata is an 8-bar colour pattern: bar index = column / (H_RES/8). Colours in order: FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
  - Timing, addressing, handshakes and frame_done are unchanged.
- Not defined: camera data path only; there is no pattern logic.

Decomposition:
- Package ov7670_pkg:
  - state enum IDLE/CAPTURE
  - H_RES/V_RES defaults
  - the RGB565->RGB444 packing function
  - the test pattern colour table
- One natural sub-module: ov7670_byte_packer.
  - Handles phase toggle, hi-byte latch and RGB444 packing.
  - Outputs a pix_valid/pix_data pair.
  - Counters, address and FSM stay in the top.

Test Plan:
- Full frame: vsync fall, 240 lines each of 640 bytes, then vsync rise.
  - Expect 76800 fb_we pulses with addresses 0..76799 strictly increasing.
  - Expect exactly one frame_done pulse.
- Packing: bytes F8,00 -> fb_wdata F00; 07,E0 -> 0F0; 00,1F -> 00F; FF,FF -> FFF. Each appears 1 cycle after the second byte.
- Overlong line of 700 bytes: only 320 writes.
  - The next line starts at address 320.
  - Overlong frame of 250 lines: no write beyond address 76799; frame_done still pulses.
- Short and odd lines: line 0 has 101 bytes.
  - Expect 50 writes (addresses 0..49); the last byte is discarded.
  - Line 1 starts at address 320.
- Abort: vsync rises after 100 lines -> no frame_done; busy drops.
  - The next vsync fall with capture_en=1 restarts at address 0.
- Control: capture_en=0 at vsync fall -> zero writes for that frame.
  - reset pulse at line 50 -> all outputs 0; capture resumes only after the next vsync fall.
